// File: rtl/mem_responder_pkg.sv
// Shared encodings for the load/store path: access sizes, responder FSM states,
// the latched request record and the alignment fault rule.
package mem_responder_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERR     = 3'd5;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  lo;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_fault(input logic [1:0] size, input logic [1:0] lo);
    return (size == SZ_RSVD) ||
           (size == SZ_HALF && lo[0]) ||
           (size == SZ_WORD && lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Little-endian lane extract/extend and sub-word merge; purely combinational.
// No state, no handshake: outputs follow inputs in the same cycle.
module mem_lane
  import mem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign,
  input  logic [15:0] wdata,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    bsel   = word[{addr_lo, 3'b000} +: 8];
    hsel   = addr_lo[1] ? word[31:16] : word[15:0];
    ext    = word;
    merged = word;
    case (size)
      SZ_HALF: begin
        ext    = {{16{sign & hsel[15]}}, hsel};
        merged = addr_lo[1] ? {wdata, word[15:0]} : {word[31:16], wdata};
      end
      SZ_BYTE: begin
        ext = {{24{sign & bsel[7]}}, bsel};
        case (addr_lo)
          2'd0:    merged = {word[31:8], wdata[7:0]};
          2'd1:    merged = {word[31:16], wdata[7:0], word[7:0]};
          2'd2:    merged = {word[31:24], wdata[7:0], word[15:0]};
          default: merged = {wdata[7:0], word[23:0]};
        endcase
      end
      default: begin
        ext    = word;
        merged = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// CPU load/store responder onto a 1-cycle-read word RAM; ready after 1 (fault), 2 (word store),
// 3 (load) or 4 (sub-word store) cycles. Single outstanding request; req is ignored while busy.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-3:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  logic [2:0]        state, state_nx;
  req_t              req_q;
  logic [ADDR_W-3:0] waddr_q;
  logic [31:0]       buf_q;
  logic [31:0]       lane_ext, lane_merged;
  logic              fault;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W];
  assign fault          = is_fault(size, addr[1:0]);

  // Lane logic sees RAM data directly so the load result and the merged
  // store word are both ready on the CAPTURE edge.
  mem_lane u_lane (
    .word    (ram_rdata),
    .size    (req_q.size),
    .addr_lo (req_q.lo),
    .sign    (req_q.sign),
    .wdata   (req_q.wdata[15:0]),
    .ext     (lane_ext),
    .merged  (lane_merged)
  );

  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE: begin
        state_nx = ST_IDLE;
        if (req) begin
          if (fault)                       state_nx = ST_ERR;
          else if (we && size == SZ_WORD)  state_nx = ST_WRITE;
          else                             state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_nx = ST_CAPTURE;
      ST_CAPTURE: state_nx = req_q.we ? ST_WRITE : ST_DONE;
      ST_WRITE:   state_nx = ST_DONE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      req_q   <= '0;
      waddr_q <= '0;
      buf_q   <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && req) begin
        req_q.we    <= we;
        req_q.size  <= size;
        req_q.sign  <= sign;
        req_q.lo    <= addr[1:0];
        req_q.wdata <= wdata;
        waddr_q     <= addr[ADDR_W-1:2];
      end
      if (state == ST_CAPTURE) begin
        buf_q <= req_q.we ? lane_merged : ram_rdata;
        if (!req_q.we) rdata <= lane_ext;
      end
    end
  end

  always_comb begin
    ready     = (state == ST_DONE) || (state == ST_ERR);
    err       = (state == ST_ERR);
    ram_we    = (state == ST_WRITE);
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == ST_ISSUE || state == ST_CAPTURE || state == ST_WRITE)
      ram_addr = waddr_q;
    if (state == ST_WRITE)
      ram_wdata = (req_q.size == SZ_WORD) ? req_q.wdata : buf_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table for single requests, plus
// reset-in-flight and back-to-back sequences against a 1-cycle-read RAM model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, err, ram_we;
  logic [31:0] rdata, ram_wdata;
  logic [31:0] ram_rdata;
  logic [5:0]  ram_addr;

  logic [31:0] mem [0:63];
  logic        init_en = 1'b0;
  logic [5:0]  init_idx = '0;
  logic [31:0] init_val = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init_en) mem[init_idx] <= init_val;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  mem_responder #(.ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign      (sign),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .err       (err),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    init_en  = 1'b1;
    init_idx = idx;
    init_val = val;
    @(posedge clk);
    #1 init_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, we_k, we_n;
    logic got_err;
    logic [31:0] got_rd, got_wd;
    preload(v.addr[7:2], v.init);
    @(negedge clk);
    req = 1'b1; we = v.we; size = v.size; sign = v.sign;
    addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0; we_k = 0; we_n = 0; got_err = 1'b0; got_rd = '0; got_wd = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ram_we) begin
        we_n++;
        we_k   = k;
        got_wd = ram_wdata;
      end
      if (ready) begin
        lat     = k;
        got_err = err;
        got_rd  = rdata;
        break;
      end
    end
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " err"}, {31'd0, got_err}, {31'd0, v.exp_err});
    chk({tag, " rdata"}, got_rd, v.exp_rdata);
    chk({tag, " ram word"}, mem[v.addr[7:2]], v.exp_mem);
    chk({tag, " ram_we count"}, we_n, v.exp_we);
    if (v.exp_we == 1) begin
      chk({tag, " ram_we cycle"}, we_k, v.exp_lat - 1);
      chk({tag, " ram_wdata"}, got_wd, v.exp_mem);
    end
  endtask

  initial begin
    int pulses, first_k, second_k, bad;
    logic [31:0] rd2;

    //           we    size   sg    addr   wdata         init          exp_rdata     exp_mem       er  lat we
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0C, 32'h0,        32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 1'b0, 3, 0};
    vecs[1]  = '{1'b0, 2'b10, 1'b1, 32'h0F, 32'h0,        32'h8899AABB, 32'hFFFFFF88, 32'h8899AABB, 1'b0, 3, 0};
    vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h0F, 32'h0,        32'h8899AABB, 32'h00000088, 32'h8899AABB, 1'b0, 3, 0};
    vecs[3]  = '{1'b0, 2'b10, 1'b1, 32'h0C, 32'h0,        32'h8899AABB, 32'hFFFFFFBB, 32'h8899AABB, 1'b0, 3, 0};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0D, 32'h0,        32'h8899AABB, 32'h000000AA, 32'h8899AABB, 1'b0, 3, 0};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h0E, 32'h0,        32'h8899AABB, 32'hFFFF8899, 32'h8899AABB, 1'b0, 3, 0};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0C, 32'h0,        32'h8899AABB, 32'h0000AABB, 32'h8899AABB, 1'b0, 3, 0};
    vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h0E, 32'h00001234, 32'h8899AABB, 32'h0000AABB, 32'h1234AABB, 1'b0, 4, 1};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h0D, 32'h00000055, 32'h8899AABB, 32'h0000AABB, 32'h889955BB, 1'b0, 4, 1};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 32'h0000AABB, 32'hDEADBEEF, 1'b0, 2, 1};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h0D, 32'h0,        32'h8899AABB, 32'h0000AABB, 32'h8899AABB, 1'b1, 1, 0};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h0F, 32'h0,        32'h8899AABB, 32'h0000AABB, 32'h8899AABB, 1'b1, 1, 0};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h0C, 32'h0,        32'h8899AABB, 32'h0000AABB, 32'h8899AABB, 1'b1, 1, 0};
    vecs[13] = '{1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFF77, 32'h11223344, 32'h0000AABB, 32'h11773344, 1'b0, 4, 1};

    #3;
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset ram_we", {31'd0, ram_we}, 32'd0);
    chk("reset ram_addr", {26'd0, ram_addr}, 32'd0);
    chk("reset ram_wdata", ram_wdata, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    #10 reset = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset lands while a byte store sits in CAPTURE.
    preload(6'd5, 32'hCAFEF00D);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; sign = 1'b0; addr = 32'h14; wdata = 32'h000000AB;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst ready", {31'd0, ready}, 32'd0);
    chk("midrst err", {31'd0, err}, 32'd0);
    chk("midrst ram_we", {31'd0, ram_we}, 32'd0);
    chk("midrst ram_addr", {26'd0, ram_addr}, 32'd0);
    chk("midrst rdata", rdata, 32'd0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ram_we || ready) bad++;
    end
    chk("midrst quiet cycles", bad, 0);
    reset = 1'b1;
    chk("midrst ram word", mem[5], 32'hCAFEF00D);
    run_vec('{1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3, 0},
            "postrst");

    // Back-to-back word loads with req held high across the first completion.
    preload(6'd3, 32'h8899AABB);
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b00; sign = 1'b0; addr = 32'h0C; wdata = 32'h0;
    pulses = 0; first_k = 0; second_k = 0; rd2 = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      if (k == 5) #1 req = 1'b0;
      @(negedge clk);
      if (ready) begin
        pulses++;
        if (pulses == 1) first_k = k;
        else if (pulses == 2) begin
          second_k = k;
          rd2 = rdata;
        end
      end
    end
    chk("b2b pulse count", pulses, 2);
    chk("b2b first ready", first_k, 3);
    chk("b2b spacing", second_k - first_k, 4);
    chk("b2b rdata", rd2, 32'h8899AABB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address bits decoded into the word RAM (RAM depth 2^(ADDR_W-2) words).
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  CPU request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 word, 01 halfword, 10 byte; 11 reserved.
- sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- ready  out  1  one-cycle completion pulse.
- err  out  1  one-cycle fault pulse, coincident with ready.
- rdata  out  32  load result, extended.
- ram_addr  out  ADDR_W-2  word address to RAM.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid one cycle after ram_addr is presented.

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, CAPTURE, WRITE, DONE, ERR.
REQ-004 SHALL, in IDLE with req=1, latch addr, wdata, size, we and sign; inputs are ignored in all other states.
REQ-005 SHALL treat the request as a fault if any of these hold: size=11; size=01 with addr[0]=1; size=00 with addr[1:0]!=00.
REQ-006 SHALL route a fault from IDLE to ERR with no RAM access.
REQ-007 SHALL route a word store IDLE -> WRITE -> DONE; all other valid requests go IDLE -> ISSUE -> CAPTURE.
REQ-008 SHALL route CAPTURE -> DONE for a load and CAPTURE -> WRITE for a sub-word store.
REQ-009 SHALL, in ISSUE, drive ram_addr = latched addr[ADDR_W-1:2] with ram_we=0.
REQ-010 SHALL, in CAPTURE, register ram_rdata into an internal word buffer.
REQ-011 SHALL use little-endian lanes: byte k = bits [8k+7:8k]; halfword at addr[1] = bits [16*addr[1]+15:16*addr[1]].
REQ-012 SHALL, for a load, select the addressed lane from the buffer, extend it per sign, and register it into rdata in the CAPTURE->DONE transition.
REQ-013 SHALL hold rdata unchanged until the next load completes; stores and faults do not modify rdata.
REQ-014 SHALL, for a sub-word store, replace only the addressed lane of the buffer with wdata[7:0] or wdata[15:0]; other lanes keep their RAM values.
REQ-015 SHALL, in WRITE, drive ram_we=1, ram_addr = latched word address, and ram_wdata = wdata (word store) or the merged buffer (sub-word store); ram_we is 0 in every other state.
REQ-016 SHALL assert ready=1 only in DONE and ERR, and err=1 only in ERR; both states return to IDLE after one cycle.
REQ-017 SHALL meet these latencies from the req-sampling edge N: ready at N+1 for ERR; N+2 for a word store; N+3 for a load; N+4 for a sub-word store.
REQ-018 SHALL NOT accept req asserted during DONE/ERR; with req held high continuously, the next request is accepted in the following IDLE cycle.
REQ-019 SHALL drive ram_addr to 0 in IDLE, DONE and ERR.

Reset
REQ-020 SHALL, on reset=0, immediately force state=IDLE, ready=0, err=0, ram_we=0, ram_addr=0, ram_wdata=0, rdata=0 and buffer=0, independent of clk.
REQ-021 SHALL abort any in-flight operation on reset with no RAM write issued; a store interrupted before WRITE leaves RAM unchanged.
REQ-022 SHALL begin accepting requests on the first rising edge after reset deasserts.

Structure
REQ-023 SHALL place the size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and the FSM state enumeration in a shared package used by mem_responder and the CPU control unit.
REQ-024 SHALL implement lane extract/extend and lane merge in one combinational sub-module, mem_lane, instantiated once in mem_responder.

Verification
REQ-025 Word load: RAM[word 3]=0x8899AABB, req addr=0x0C size=00 -> ready at N+3, rdata=0x8899AABB, err=0.
REQ-026 Byte loads: same RAM, addr=0x0F size=10 sign=1 -> rdata=0xFFFFFF88; sign=0 -> rdata=0x00000088.
REQ-027 Halfword store: RAM[word 3]=0x8899AABB, addr=0x0E size=01 wdata=0x00001234 -> ram_we at N+3 with ram_wdata=0x1234AABB, ready at N+4.
REQ-028 Misaligned word: addr=0x0D size=00 -> ready=err=1 at N+1, ram_we never 1, rdata unchanged.
REQ-029 Reset mid-operation: sub-word store, reset=0 during CAPTURE -> ram_we stays 0, RAM unchanged, ready=0; after release, a word load returns the original RAM value.
REQ-030 Back-to-back: req held high for two word loads -> ready pulses exactly once per request, second pulse 4 cycles after the first.
